alu_pipe: RTL and testbench

Parametrised, handshaked successor to the CPU's combinational ALU. Performs the existing ADD/SUB/logic/shift/immediate-merge operations with a registered one-cycle latency, and adds an iterative signed fixed-point multiply for the neural-network datapath. Adds optional saturating arithmetic and correct overflow for every signed operation. Sits between register-file read and writeback in the CPU, with valid/ready handshakes so a multi-cycle multiply can stall the pipeline.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_pipe_if.sv | 29 ++
 rtl/mul_iter.sv | 114 +++++++++++
 rtl/alu_pipe.sv | 164 ++++++++++++++++
 tb/tb_alu_pipe.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   alu_op_t    - 5-bit opcode encoding carried on ctrl.
//   alu_state_t - control state of alu_pipe (IDLE / MUL).
package alu_pkg;

  localparam int unsigned CTRL_W = 5;

  // 0x0A and 0x0B are legacy aliases of ADD kept for binary compatibility.
  typedef enum logic [CTRL_W-1:0] {
    OP_ADD   = 5'h00,
    OP_SUB   = 5'h01,
    OP_AND   = 5'h02,
    OP_OR    = 5'h03,
    OP_XOR   = 5'h04,
    OP_SLL   = 5'h05,
    OP_SRA   = 5'h06,
    OP_IMML  = 5'h08,
    OP_IMMH  = 5'h09,
    OP_ADD_A = 5'h0A,
    OP_ADD_B = 5'h0B,
    OP_MUL   = 5'h0C
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle of alu_pipe.
//   in_valid/in_ready   - operation handshake (a, b, ctrl)
//   out_valid/out_ready - result handshake (out, ovfl)
//   busy                - a multiply is in progress
// master = producer of operations / consumer of results, slave = the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ovfl;
  logic             busy;

  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, out, ovfl, busy
  );

  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, out, ovfl, busy
  );
endinterface

// File: rtl/mul_iter.sv
// mul_iter: iterative signed fixed-point multiplier.
//   start_i    - load operands (a_i, b_i) and begin WIDTH shift-add steps
//   done_o     - all steps finished; res_o/ovfl_o/neg_o valid this cycle
//   res_o      - low WIDTH bits of (a*b) >>> FRAC
//   ovfl_o     - shifted product outside the signed WIDTH range
//   neg_o      - sign of the shifted product (saturation direction)
// Works on operand magnitudes, one multiplier bit per cycle; the sign is
// applied to the full 2*WIDTH product before the fraction shift so the
// shift truncates toward minus infinity.
module mul_iter #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             ovfl_o,
  output logic             neg_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] shifted_s;

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      mag = ~v + WIDTH'(1);
    end else begin
      mag = v;
    end
  endfunction

  // Next-state for the shift-add datapath and step counter.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      cnt_d    = CW'(WIDTH);
      active_d = 1'b1;
      neg_d    = a_i[WIDTH-1] ^ b_i[WIDTH-1];
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, mag(a_i)};
      mplier_d = mag(b_i);
    end else if (active_q) begin
      if (cnt_q != '0) begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end else begin
        // done_o is high this cycle; the owner captures the result now.
        active_d = 1'b0;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Datapath registers; reset discards any partial product.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Sign fix, fraction shift and range check of the finished product.
  always_comb begin
    if (neg_q) begin
      prod_s = ~acc_q + (2*WIDTH)'(1);
    end else begin
      prod_s = acc_q;
    end
    shifted_s = $unsigned($signed(prod_s) >>> FRAC);
    res_o     = shifted_s[WIDTH-1:0];
    neg_o     = shifted_s[2*WIDTH-1];
    // In range only if every bit from WIDTH-1 upward is a sign copy.
    ovfl_o    = !((&shifted_s[2*WIDTH-1:WIDTH-1]) || !(|shifted_s[2*WIDTH-1:WIDTH-1]));
  end

  assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered results.
//   clk, rst - single clock, synchronous active-high reset
//   bus      - alu_pipe_if slave: in_valid/in_ready/a/b/ctrl in,
//              out_valid/out_ready/out/ovfl out, busy during MUL
// Single-cycle ops are computed combinationally at acceptance and land in
// the output register one edge later; MUL hands off to mul_iter and blocks
// new operations until its result is registered.
import alu_pkg::*;

module alu_pipe #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int SATURATE = 0
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  localparam int SH = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_t       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovfl_q, ovfl_d;

  alu_op_t          op_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             is_mul_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovfl_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_res_s;
  logic             mul_ovfl_s;
  logic             mul_neg_s;

  // Wrap or clamp a signed result depending on SATURATE.
  function automatic logic [WIDTH-1:0] sat_pick(input logic [WIDTH-1:0] wrap,
                                                input logic ov, input logic neg);
    if ((SATURATE != 0) && ov) begin
      sat_pick = neg ? SMIN : SMAX;
    end else begin
      sat_pick = wrap;
    end
  endfunction

  assign op_s       = alu_op_t'(bus.ctrl);
  assign is_mul_s   = (op_s == OP_MUL);
  assign in_ready_s = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // One extra sign bit makes a - (-2^(WIDTH-1)) exact; the top two bits
  // disagree exactly on signed overflow and the top bit gives the direction.
  assign sum_s  = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
  assign diff_s = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};

  // Single-cycle operation unit.
  always_comb begin
    alu_res_s  = '0;
    alu_ovfl_s = 1'b0;
    case (op_s)
      OP_ADD, OP_ADD_A, OP_ADD_B: begin
        alu_ovfl_s = sum_s[WIDTH] ^ sum_s[WIDTH-1];
        alu_res_s  = sat_pick(sum_s[WIDTH-1:0], alu_ovfl_s, sum_s[WIDTH]);
      end
      OP_SUB: begin
        alu_ovfl_s = diff_s[WIDTH] ^ diff_s[WIDTH-1];
        alu_res_s  = sat_pick(diff_s[WIDTH-1:0], alu_ovfl_s, diff_s[WIDTH]);
      end
      OP_AND:  alu_res_s = bus.a & bus.b;
      OP_OR:   alu_res_s = bus.a | bus.b;
      OP_XOR:  alu_res_s = bus.a ^ bus.b;
      OP_SLL:  alu_res_s = bus.a << bus.b[SH-1:0];
      OP_SRA:  alu_res_s = $unsigned($signed(bus.a) >>> bus.b[SH-1:0]);
      OP_IMML: alu_res_s = {bus.a[WIDTH-1:WIDTH/2], bus.b[WIDTH/2-1:0]};
      OP_IMMH: alu_res_s = {bus.b[WIDTH/2-1:0], bus.a[WIDTH/2-1:0]};
      default: begin
        alu_res_s  = '0;
        alu_ovfl_s = 1'b0;
      end
    endcase
  end

  mul_iter #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept_s && is_mul_s),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (mul_done_s),
    .res_o   (mul_res_s),
    .ovfl_o  (mul_ovfl_s),
    .neg_o   (mul_neg_s)
  );

  // FSM next state and output register next values.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ovfl_d  = ovfl_q;
    // A consumed result drops unless a new one is written below.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_d = MUL;
          end else begin
            out_valid_d = 1'b1;
            out_d       = alu_res_s;
            ovfl_d      = alu_ovfl_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_d       = sat_pick(mul_res_s, mul_ovfl_s, mul_neg_s);
          ovfl_d      = mul_ovfl_s;
        end else begin
          state_d = MUL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovfl_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovfl_q      <= ovfl_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.ovfl      = ovfl_q;
  assign bus.busy      = (state_q == MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe. Two instances (wrap and
// saturate) receive identical stimulus; every accepted operation pushes the
// reference results of both onto a queue that is popped on each output
// handshake. Directed sequences add latency, stall and reset checks.
module tb_alu_pipe;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  typedef struct packed {
    logic [15:0] o0;
    logic        v0;
    logic [15:0] o1;
    logic        v1;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid_r;
  logic        out_ready_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [4:0]  ctrl_r;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [16:0] mon_m0;
  logic [16:0] mon_m1;
  int          n_checks;
  int          n_errors;

  alu_pipe_if #(.WIDTH(WIDTH)) if0 ();
  alu_pipe_if #(.WIDTH(WIDTH)) if1 ();

  assign if0.in_valid  = in_valid_r;
  assign if0.a         = a_r;
  assign if0.b         = b_r;
  assign if0.ctrl      = ctrl_r;
  assign if0.out_ready = out_ready_r;
  assign if1.in_valid  = in_valid_r;
  assign if1.a         = a_r;
  assign if1.b         = b_r;
  assign if1.ctrl      = ctrl_r;
  assign if1.out_ready = out_ready_r;

  alu_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .SATURATE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  alu_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .SATURATE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: returns {ovfl, out}.
  function automatic logic [16:0] model(input logic [4:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input bit sat);
    longint sa;
    longint sb;
    longint r;
    logic   ov;
    logic [15:0] o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    ov = 1'b0;
    o  = 16'h0000;
    case (op)
      5'h00, 5'h0A, 5'h0B, 5'h01, 5'h0C: begin
        if (op == 5'h01)      r = sa - sb;
        else if (op == 5'h0C) r = (sa * sb) >>> FRAC;
        else                  r = sa + sb;
        ov = (r > 32767) || (r < -32768);
        if (sat && ov) o = (r < 0) ? 16'h8000 : 16'h7FFF;
        else           o = r[15:0];
      end
      5'h02: o = a & b;
      5'h03: o = a | b;
      5'h04: o = a ^ b;
      5'h05: o = a << b[3:0];
      5'h06: o = $signed(a) >>> b[3:0];
      5'h08: o = {a[15:8], b[7:0]};
      5'h09: o = {b[7:0], a[7:0]};
      default: o = 16'h0000;
    endcase
    return {ov, o};
  endfunction

  // Scoreboard: pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (if0.out_valid && out_ready_r) begin
        check_val("lockstep_valid", {31'd0, if1.out_valid}, 32'd1);
        if (sb_q.size() == 0) begin
          check_val("unexpected_result", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("sb_out_wrap",  {16'd0, if0.out}, {16'd0, mon_e.o0});
          check_val("sb_ovfl_wrap", {31'd0, if0.ovfl}, {31'd0, mon_e.v0});
          check_val("sb_out_sat",   {16'd0, if1.out}, {16'd0, mon_e.o1});
          check_val("sb_ovfl_sat",  {31'd0, if1.ovfl}, {31'd0, mon_e.v1});
        end
      end
      if (in_valid_r && if0.in_ready) begin
        mon_m0 = model(ctrl_r, a_r, b_r, 1'b0);
        mon_m1 = model(ctrl_r, a_r, b_r, 1'b1);
        sb_q.push_back('{o0: mon_m0[15:0], v0: mon_m0[16], o1: mon_m1[15:0], v1: mon_m1[16]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int waited);
    ctrl_r     = op;
    a_r        = a;
    b_r        = b;
    in_valid_r = 1'b1;
    waited     = 0;
    @(negedge clk);
    while (!if0.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 100) check_val("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid_r = 1'b0;
  endtask

  // Checks the result visible at the next negedge against constants.
  task automatic check_res(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic eov);
    @(negedge clk);
    check_val({tag, "_valid"}, {31'd0, if0.out_valid}, 32'd1);
    check_val({tag, "_out"},   {16'd0, if0.out}, {16'd0, e0});
    check_val({tag, "_sat"},   {16'd0, if1.out}, {16'd0, e1});
    check_val({tag, "_ovfl"},  {30'd0, if0.ovfl, if1.ovfl}, {30'd0, eov, eov});
    check_val({tag, "_busy"},  {31'd0, if0.busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e0, input logic [15:0] e1, input logic eov);
    int w;
    int bad;
    issue(5'h0C, a, b, w);
    bad = 0;
    repeat (17) begin
      @(negedge clk);
      if (if0.out_valid !== 1'b0 || if0.busy !== 1'b1 || if0.in_ready !== 1'b0) bad++;
    end
    check_val({tag, "_stall"}, bad, 32'd0);
    check_res(tag, e0, e1, eov);
  endtask

  initial begin
    int w;
    int bad;
    logic [15:0] held_out;
    logic        held_ovfl;
    logic [4:0]  op_list [14];
    logic [4:0]  b2b_op [4];
    logic [15:0] b2b_a [4];
    logic [15:0] b2b_b [4];

    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    in_valid_r  = 1'b0;
    out_ready_r = 1'b1;
    a_r         = 16'h0000;
    b_r         = 16'h0000;
    ctrl_r      = 5'h00;
    op_list = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
                5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h1F};
    b2b_op  = '{5'h04, 5'h05, 5'h06, 5'h09};
    b2b_a   = '{16'hA5A5, 16'h0001, 16'h8000, 16'h1234};
    b2b_b   = '{16'hFFFF, 16'h0004, 16'h0004, 16'h00AB};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    check_val("rst_out",       {16'd0, if0.out}, 32'd0);
    check_val("rst_ovfl",      {31'd0, if0.ovfl}, 32'd0);
    check_val("rst_busy",      {31'd0, if0.busy}, 32'd0);
    check_val("rst_in_ready",  {31'd0, if0.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Signed add/sub overflow and one-cycle latency.
    issue(5'h00, 16'h7FFF, 16'h0001, w);
    check_res("add_ovf", 16'h8000, 16'h7FFF, 1'b1);
    issue(5'h01, 16'h0000, 16'h8000, w);
    check_res("sub_min", 16'h8000, 16'h7FFF, 1'b1);
    issue(5'h01, 16'h0005, 16'h0007, w);
    check_res("sub_small", 16'hFFFE, 16'hFFFE, 1'b0);

    // Fixed-point multiply.
    run_mul("mul_neg", 16'h0180, 16'hFE00, 16'hFD00, 16'hFD00, 1'b0);
    run_mul("mul_big", 16'h7F00, 16'h7F00, 16'h0100, 16'h7FFF, 1'b1);
    run_mul("mul_min", 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 1'b1);

    // Backpressure: result held, no acceptance, then same-edge accept.
    out_ready_r = 1'b0;
    issue(5'h02, 16'hF0F0, 16'h3C3C, w);
    @(negedge clk);
    held_out  = if0.out;
    held_ovfl = if0.ovfl;
    check_val("bp_and", {16'd0, held_out}, 32'h3030);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (if0.out !== held_out || if0.ovfl !== held_ovfl ||
          if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0) bad++;
    end
    check_val("bp_hold", bad, 32'd0);
    @(posedge clk);
    #1;
    out_ready_r = 1'b1;
    issue(5'h03, 16'h1234, 16'h0F0F, w);
    check_val("bp_same_edge", w, 32'd0);
    check_res("bp_next", 16'h1F3F, 16'h1F3F, 1'b0);

    // Reset five cycles into a multiply.
    issue(5'h0C, 16'h0180, 16'h0200, w);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("mrst_state", {29'd0, if0.out_valid, if0.busy, if0.in_ready}, 32'd1);
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (if0.out_valid !== 1'b0) bad++;
    end
    check_val("mrst_no_result", bad, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      ctrl_r     = b2b_op[i];
      a_r        = b2b_a[i];
      b_r        = b2b_b[i];
      in_valid_r = 1'b1;
      @(negedge clk);
      check_val("b2b_ready", {31'd0, if0.in_ready}, 32'd1);
      if (i > 0) check_val("b2b_valid", {31'd0, if0.out_valid}, 32'd1);
      if (i == 3) check_val("b2b_sra", {16'd0, if0.out}, 32'h0000F800);
      @(posedge clk);
      #1;
    end
    in_valid_r = 1'b0;
    @(negedge clk);
    check_val("b2b_last", {15'd0, if0.out_valid, if0.out}, {15'd0, 1'b1, 16'hAB34});
    @(posedge clk);
    #1;

    // Random mix with idle gaps and short consumer stalls.
    for (int i = 0; i < 40; i++) begin
      out_ready_r = 1'b1;
      issue(op_list[$urandom_range(0, 13)], 16'($urandom), 16'($urandom), w);
      repeat ($urandom_range(0, 2)) begin
        out_ready_r = ($urandom_range(0, 2) != 0);
        @(posedge clk);
        #1;
      end
    end
    out_ready_r = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_val("sb_drain", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
